jtag_tap_dbus_responder: RTL and testbench
==========================================

// Module: jtag_tap_dbus_responder
// PURPOSE
//  Target-side end of the JTAG pins the SoC bench drives (tclk, tms, tdi). Contains the IEEE 1149.1
//  16-state TAP FSM, a 4-bit IR, and three data registers: IDCODE, BYPASS and DBUS.
//  DBUS turns shifted scan words into single read/write requests on a req/ack debug bus.
//  This block sits between the pad ring and the debug/bus bridge.
// PARAMETERS
//  IDCODE_VAL  32'h1000_0B6D  value captured by IDCODE; bit0 must be 1
//  ADDR_W      8              debug-bus address width
//  DBUS_W      ADDR_W+34      DBUS scan length: {addr, data[31:0], op[1:0]}, op at LSBs
// PORTS
//  jtg_tclk     in   1       sole clock; every flop is on the rising edge
//  jtg_trst     in   1       asynchronous, active-high reset
//  jtg_tms      in   1       TAP mode select, sampled on the rising edge
//  jtg_tdi      in   1       serial data in
//  jtg_tdo      out  1       serial data out
//  jtg_tdo_en   out  1       TDO drive enable; high only in Shift-IR and Shift-DR
//  dbus_req     out  1       request; held high until dbus_ack is seen
//  dbus_wr      out  1       1 = write, 0 = read; stable while dbus_req is high
//  dbus_addr    out  ADDR_W  request address; stable while dbus_req is high
//  dbus_wdata   out  32      write data; stable while dbus_req is high
//  dbus_rdata   in   32      read data; valid in the cycle dbus_ack is high
//  dbus_ack     in   1       completion; ignored when dbus_req is low
//  tap_state    out  4       current TAP state (debug visibility)
// BEHAVIOUR
//  Reset: state=TEST_LOGIC_RESET (TLR), IR=4'h1 (IDCODE). All outputs are 0.
//    The last-address, last-rdata and sticky-busy registers are also 0.
//  FSM: standard 1149.1 transitions on jtg_tms at each rising edge.
//    Five consecutive tms=1 cycles reach TLR from any state. tms held high keeps the FSM in TLR.
//    Entering TLR loads IR=IDCODE. It does not abort an outstanding dbus_req.
//  IR: Capture-IR loads 4'b0101. Shift-IR shifts LSB-first, tdi into the MSB. Update-IR commits.
//    Decode: 4'h1 IDCODE, 4'h2 DBUS, 4'hF BYPASS. Every other code selects BYPASS.
//  Capture-DR:
//    IDCODE loads IDCODE_VAL. BYPASS loads 1'b0.
//    DBUS loads {last_addr, last_rdata, status}. status=2'b11 if dbus_req is high or sticky-busy is set.
//    Otherwise status=2'b00.
//  Shift-DR: the selected register shifts right and tdi enters the MSB.
//  TDO: jtg_tdo = bit0 of the active shift register (combinational) while in Shift-IR or Shift-DR.
//    In every other state jtg_tdo=0 and jtg_tdo_en=0.
//  Update-DR with DBUS selected, op=scan[1:0]:
//    - dbus_req high -> request ignored; sticky-busy<=1.
//    - op=00 -> no request; sticky-busy<=0.
//    - op=01 read or op=10 write, with sticky-busy=0 ->
//      dbus_req<=1 in the next cycle; dbus_wr, dbus_addr, dbus_wdata are latched from the scan word;
//      last_addr<=addr.
//    - op=11, or sticky-busy=1 -> ignored.
//  Handshake:
//    - On a rising edge with dbus_req=1 and dbus_ack=1: dbus_req<=0.
//    - A read also loads last_rdata<=dbus_rdata on that edge. Minimum request length is 1 cycle.
//    - Update-DR and ack on the same edge: the ack completes the current request; the new op is
//      ignored (busy rule).
//  Reset mid-transaction: jtg_trst drops dbus_req immediately. Any later ack is ignored.
//  Width rules: DR shift length equals the selected register width exactly. There is no wrap.
//    Extra shifted bits fall out through TDO.
// STRUCTURE
//  Package jtag_tap_pkg holds:
//    - 4-bit TAP state encodings (TLR..UPDATE_IR);
//    - IR opcodes IR_IDCODE, IR_DBUS, IR_BYPASS and the IR capture constant 4'b0101;
//    - DBUS op codes and status codes.
//  Sub-module jtag_tap_fsm holds the 16-state next-state logic and state flop.
//    It outputs tap_state and one-hot strobes: capture_ir/dr, shift_ir/dr, update_ir/dr, in_tlr.
//  The top level holds the IR, the DR shift registers and the dbus handshake.
// TESTING
//  1. Hold tms=1 from reset for 20 cycles -> tap_state=TLR throughout, jtg_tdo_en=0, dbus_req=0.
//  2. From Run-Idle go to Shift-DR with the default IR and shift 32 bits
//     -> TDO yields 32'h1000_0B6D LSB-first.
//  3. Load IR=4'hF and shift DR 0xA5 (8 bits) -> TDO returns 0 followed by the first 7 bits of 0xA5,
//     a one-cycle delay.
//  4. IR=4'h2, scan {8'h3C, 32'hDEAD_BEEF, 2'b10}, Update-DR
//     -> dbus_req=1, wr=1, addr=8'h3C, wdata=DEADBEEF. ack after 3 cycles -> req falls on the ack edge.
//  5. Scan a read (op=01, addr 8'h10) with rdata=32'h1234_5678 on ack. Then Capture-DR and shift
//     -> {8'h10, 32'h1234_5678, 2'b00}.
//  6. Issue a second write while ack is withheld -> ignored; next capture shows status=11.
//     Then ack, scan op=00, capture -> status=00. Assert jtg_trst while req is high -> req=0 at once.

Source files
------------

// File: rtl/jtag_tap_pkg.sv
// Shared encodings for the JTAG TAP debug-bus responder: TAP states, IR opcodes,
// DBUS op/status codes and the IR-to-data-register decode.
package jtag_tap_pkg;

  localparam int unsigned IR_W = 4;

  typedef enum logic [3:0] {
    TLR        = 4'h0,
    RUN_IDLE   = 4'h1,
    SELECT_DR  = 4'h2,
    CAPTURE_DR = 4'h3,
    SHIFT_DR   = 4'h4,
    EXIT1_DR   = 4'h5,
    PAUSE_DR   = 4'h6,
    EXIT2_DR   = 4'h7,
    UPDATE_DR  = 4'h8,
    SELECT_IR  = 4'h9,
    CAPTURE_IR = 4'hA,
    SHIFT_IR   = 4'hB,
    EXIT1_IR   = 4'hC,
    PAUSE_IR   = 4'hD,
    EXIT2_IR   = 4'hE,
    UPDATE_IR  = 4'hF
  } tap_state_e;

  localparam logic [IR_W-1:0] IR_IDCODE  = 4'h1;
  localparam logic [IR_W-1:0] IR_DBUS    = 4'h2;
  localparam logic [IR_W-1:0] IR_BYPASS  = 4'hF;
  localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0101;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b11;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_DBUS   = 2'd2
  } dr_sel_e;

  // Unknown opcodes fall back to BYPASS.
  function automatic dr_sel_e decode_ir(input logic [IR_W-1:0] code);
    case (code)
      IR_IDCODE: return DR_IDCODE;
      IR_DBUS:   return DR_DBUS;
      default:   return DR_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_dbus_responder_fsm.sv
// IEEE 1149.1 16-state TAP controller with one-hot state strobes.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output logic [3:0] tap_state,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       in_tlr
);

  tap_state_e state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TLR;
    end else begin
      case (state)
        TLR:        state <= tms ? TLR       : RUN_IDLE;
        RUN_IDLE:   state <= tms ? SELECT_DR : RUN_IDLE;
        SELECT_DR:  state <= tms ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR: state <= tms ? EXIT1_DR  : SHIFT_DR;
        SHIFT_DR:   state <= tms ? EXIT1_DR  : SHIFT_DR;
        EXIT1_DR:   state <= tms ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:   state <= tms ? EXIT2_DR  : PAUSE_DR;
        EXIT2_DR:   state <= tms ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:  state <= tms ? SELECT_DR : RUN_IDLE;
        SELECT_IR:  state <= tms ? TLR       : CAPTURE_IR;
        CAPTURE_IR: state <= tms ? EXIT1_IR  : SHIFT_IR;
        SHIFT_IR:   state <= tms ? EXIT1_IR  : SHIFT_IR;
        EXIT1_IR:   state <= tms ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:   state <= tms ? EXIT2_IR  : PAUSE_IR;
        EXIT2_IR:   state <= tms ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:  state <= tms ? SELECT_DR : RUN_IDLE;
        default:    state <= TLR;
      endcase
    end
  end

  // Strobes are pure decodes of the state flop.
  assign tap_state  = state;
  assign capture_ir = (state == CAPTURE_IR);
  assign shift_ir   = (state == SHIFT_IR);
  assign update_ir  = (state == UPDATE_IR);
  assign capture_dr = (state == CAPTURE_DR);
  assign shift_dr   = (state == SHIFT_DR);
  assign update_dr  = (state == UPDATE_DR);
  assign in_tlr     = (state == TLR);

endmodule

// File: rtl/jtag_tap_dbus_responder.sv
// JTAG TAP with IDCODE, BYPASS and a DBUS register that turns scan words into
// single read/write requests on a req/ack debug bus.
module jtag_tap_dbus_responder
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0B6D,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              jtg_tclk,
  input  logic              jtg_trst,
  input  logic              jtg_tms,
  input  logic              jtg_tdi,
  output logic              jtg_tdo,
  output logic              jtg_tdo_en,
  output logic              dbus_req,
  output logic              dbus_wr,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [31:0]       dbus_wdata,
  input  logic [31:0]       dbus_rdata,
  input  logic              dbus_ack,
  output logic [3:0]        tap_state
);

  localparam int unsigned DBUS_W = ADDR_W + 34;

  logic capture_ir, shift_ir, update_ir;
  logic capture_dr, shift_dr, update_dr, in_tlr;

  jtag_tap_fsm u_fsm (
    .clk        (jtg_tclk),
    .rst        (jtg_trst),
    .tms        (jtg_tms),
    .tap_state  (tap_state),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .in_tlr     (in_tlr)
  );

  logic [IR_W-1:0]   ir, ir_sr;
  dr_sel_e           dr_sel;
  logic [31:0]       idcode_sr;
  logic              bypass_sr;
  logic [DBUS_W-1:0] dbus_sr;
  logic [ADDR_W-1:0] last_addr;
  logic [31:0]       last_rdata;
  logic              sticky_busy;
  logic [1:0]        status;
  logic [1:0]        scan_op;
  logic [31:0]       scan_data;
  logic [ADDR_W-1:0] scan_addr;

  assign dr_sel    = decode_ir(ir);
  assign status    = (dbus_req || sticky_busy) ? ST_BUSY : ST_IDLE;
  assign scan_op   = dbus_sr[1:0];
  assign scan_data = dbus_sr[33:2];
  assign scan_addr = dbus_sr[DBUS_W-1:34];

  // Instruction register: capture/shift path plus committed IR.
  always_ff @(posedge jtg_tclk or posedge jtg_trst) begin
    if (jtg_trst) begin
      ir    <= IR_IDCODE;
      ir_sr <= '0;
    end else begin
      if (capture_ir)    ir_sr <= IR_CAPTURE;
      else if (shift_ir) ir_sr <= {jtg_tdi, ir_sr[IR_W-1:1]};
      if (in_tlr)         ir <= IR_IDCODE;
      else if (update_ir) ir <= ir_sr;
    end
  end

  // Data registers; only the selected one captures or shifts.
  always_ff @(posedge jtg_tclk or posedge jtg_trst) begin
    if (jtg_trst) begin
      idcode_sr <= '0;
      bypass_sr <= 1'b0;
      dbus_sr   <= '0;
    end else if (capture_dr) begin
      case (dr_sel)
        DR_IDCODE: idcode_sr <= IDCODE_VAL;
        DR_DBUS:   dbus_sr   <= {last_addr, last_rdata, status};
        default:   bypass_sr <= 1'b0;
      endcase
    end else if (shift_dr) begin
      case (dr_sel)
        DR_IDCODE: idcode_sr <= {jtg_tdi, idcode_sr[31:1]};
        DR_DBUS:   dbus_sr   <= {jtg_tdi, dbus_sr[DBUS_W-1:1]};
        default:   bypass_sr <= jtg_tdi;
      endcase
    end
  end

  always_comb begin
    jtg_tdo = 1'b0;
    if (shift_ir) begin
      jtg_tdo = ir_sr[0];
    end else if (shift_dr) begin
      case (dr_sel)
        DR_IDCODE: jtg_tdo = idcode_sr[0];
        DR_DBUS:   jtg_tdo = dbus_sr[0];
        default:   jtg_tdo = bypass_sr;
      endcase
    end
  end

  assign jtg_tdo_en = shift_ir | shift_dr;

  // Debug-bus handshake; an ack completes before a same-edge update is judged busy.
  always_ff @(posedge jtg_tclk or posedge jtg_trst) begin
    if (jtg_trst) begin
      dbus_req    <= 1'b0;
      dbus_wr     <= 1'b0;
      dbus_addr   <= '0;
      dbus_wdata  <= '0;
      last_addr   <= '0;
      last_rdata  <= '0;
      sticky_busy <= 1'b0;
    end else begin
      if (dbus_req && dbus_ack) begin
        dbus_req <= 1'b0;
        if (!dbus_wr) last_rdata <= dbus_rdata;
      end
      if (update_dr && (dr_sel == DR_DBUS)) begin
        if (dbus_req) begin
          sticky_busy <= 1'b1;
        end else if (scan_op == OP_NOP) begin
          sticky_busy <= 1'b0;
        end else if (((scan_op == OP_READ) || (scan_op == OP_WRITE)) && !sticky_busy) begin
          dbus_req   <= 1'b1;
          dbus_wr    <= (scan_op == OP_WRITE);
          dbus_addr  <= scan_addr;
          dbus_wdata <= scan_data;
          last_addr  <= scan_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_dbus_responder.sv
// Directed and randomized bench for jtag_tap_dbus_responder against a
// transaction-level model of the TAP, its data registers and the debug bus.
module tb_jtag_tap_dbus_responder;
  import jtag_tap_pkg::*;

  localparam int unsigned AW     = 8;
  localparam int unsigned DW     = AW + 34;
  localparam logic [31:0] ID_EXP = 32'h1000_0B6D;

  logic          clk = 1'b0;
  logic          trst, tms, tdi, tdo, tdo_en, req, wr, ack;
  logic [AW-1:0] addr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    tstate;

  always #5 clk = ~clk;

  jtag_tap_dbus_responder dut (
    .jtg_tclk   (clk),
    .jtg_trst   (trst),
    .jtg_tms    (tms),
    .jtg_tdi    (tdi),
    .jtg_tdo    (tdo),
    .jtg_tdo_en (tdo_en),
    .dbus_req   (req),
    .dbus_wr    (wr),
    .dbus_addr  (addr),
    .dbus_wdata (wdata),
    .dbus_rdata (rdata),
    .dbus_ack   (ack),
    .tap_state  (tstate)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0]    nxt [16][2];
  logic [3:0]    m_state, m_ir, m_ir_scan;
  logic          m_req, m_wr, m_busy;
  logic [AW-1:0] m_addr, m_last_addr;
  logic [31:0]   m_wdata, m_last_rdata;
  logic [63:0]   m_cap, m_scan;
  logic          last_tdo;
  bit            rand_ack = 1'b0;
  bit            walk = 1'b0;
  int            ones = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arc(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
    nxt[s][0] = n0;
    nxt[s][1] = n1;
  endtask

  task automatic model_reset();
    m_state = TLR; m_ir = IR_IDCODE; m_req = 1'b0; m_wr = 1'b0; m_busy = 1'b0;
    m_addr = '0; m_wdata = '0; m_last_addr = '0; m_last_rdata = '0; ones = 0;
  endtask

  function automatic int dr_w(input logic [3:0] code);
    if (code == IR_IDCODE) return 32;
    if (code == IR_DBUS) return int'(DW);
    return 1;
  endfunction

  // One TCK cycle: drive at negedge, sample TDO before the rising edge, check after it.
  task automatic step(input logic t_ms, input logic t_di);
    logic [3:0] s;
    logic       o_en, shifting, issue;
    logic [1:0] op;
    @(negedge clk);
    tms = t_ms; tdi = t_di;
    if (rand_ack) begin
      ack = ($urandom_range(3) == 0);
      rdata = $urandom;
    end
    #1;
    last_tdo = tdo; o_en = tdo_en;
    s = m_state;
    shifting = (s == SHIFT_IR) || (s == SHIFT_DR);
    chk("tdo_en", 64'(o_en), 64'(shifting));
    if (!shifting) chk("tdo_idle", 64'(last_tdo), 64'd0);
    @(posedge clk); #1;
    if (s == CAPTURE_DR) begin
      if (m_ir == IR_IDCODE)   m_cap = 64'(ID_EXP);
      else if (m_ir == IR_DBUS) m_cap = 64'({m_last_addr, m_last_rdata, (m_req || m_busy) ? 2'b11 : 2'b00});
      else                      m_cap = 64'd0;
    end
    issue = 1'b0;
    op = m_scan[1:0];
    if (s == UPDATE_DR && m_ir == IR_DBUS) begin
      if (m_req)                             m_busy = 1'b1;
      else if (op == 2'b00)                  m_busy = 1'b0;
      else if (op != 2'b11 && !m_busy)       issue = 1'b1;
    end
    if (s == TLR)            m_ir = IR_IDCODE;
    else if (s == UPDATE_IR) m_ir = walk ? 4'hF : m_ir_scan;
    if (m_req && ack) begin
      m_req = 1'b0;
      if (!m_wr) m_last_rdata = rdata;
    end
    if (issue) begin
      m_req = 1'b1; m_wr = (op == 2'b10);
      m_addr = m_scan[AW+33:34]; m_wdata = m_scan[33:2]; m_last_addr = m_addr;
    end
    m_state = nxt[s][t_ms];
    ones = t_ms ? ones + 1 : 0;
    chk("tap_state", 64'(tstate), 64'(m_state));
    if (ones >= 5) chk("tlr_after_5_tms", 64'(tstate), 64'(TLR));
    chk("dbus_req", 64'(req), 64'(m_req));
    if (m_req) begin
      chk("dbus_wr", 64'(wr), 64'(m_wr));
      chk("dbus_addr", 64'(addr), 64'(m_addr));
      chk("dbus_wdata", 64'(wdata), 64'(m_wdata));
    end
  endtask

  // Full DR scan from Run-Idle back to Run-Idle; checks TDO against the captured value.
  task automatic scan_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
    logic [63:0] exp;
    int w, k;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    w = dr_w(m_ir);
    dout = '0; exp = '0;
    for (int i = 0; i < len; i++) begin
      step(i == len - 1, din[i]);
      dout[i] = last_tdo;
      exp[i] = (i < w) ? m_cap[i] : din[i - w];
    end
    chk("dr_scan_out", dout, exp);
    m_scan = '0;
    for (int j = 0; j < w; j++) begin
      k = len - w + j;
      m_scan[j] = (k >= 0) ? din[k] : m_cap[j + len];
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic scan_ir(input logic [3:0] code);
    logic [3:0] o;
    m_ir_scan = code;
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, code[i]);
      o[i] = last_tdo;
    end
    chk("ir_capture", 64'(o), 64'(4'b0101));
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] d, word;
    arc(TLR, RUN_IDLE, TLR);          arc(RUN_IDLE, RUN_IDLE, SELECT_DR);
    arc(SELECT_DR, CAPTURE_DR, SELECT_IR); arc(CAPTURE_DR, SHIFT_DR, EXIT1_DR);
    arc(SHIFT_DR, SHIFT_DR, EXIT1_DR); arc(EXIT1_DR, PAUSE_DR, UPDATE_DR);
    arc(PAUSE_DR, PAUSE_DR, EXIT2_DR); arc(EXIT2_DR, SHIFT_DR, UPDATE_DR);
    arc(UPDATE_DR, RUN_IDLE, SELECT_DR); arc(SELECT_IR, CAPTURE_IR, TLR);
    arc(CAPTURE_IR, SHIFT_IR, EXIT1_IR); arc(SHIFT_IR, SHIFT_IR, EXIT1_IR);
    arc(EXIT1_IR, PAUSE_IR, UPDATE_IR); arc(PAUSE_IR, PAUSE_IR, EXIT2_IR);
    arc(EXIT2_IR, SHIFT_IR, UPDATE_IR); arc(UPDATE_IR, RUN_IDLE, SELECT_DR);

    trst = 1'b1; tms = 1'b1; tdi = 1'b0; ack = 1'b0; rdata = '0;
    m_scan = '0; m_cap = '0; m_ir_scan = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", 64'(tstate), 64'(TLR));
    chk("rst_tdo", 64'(tdo), 64'd0);
    chk("rst_tdo_en", 64'(tdo_en), 64'd0);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_outs", 64'({wr, addr, wdata}), 64'd0);
    @(negedge clk); trst = 1'b0;

    // Hold tms high: stays in TLR
    repeat (20) step(1'b1, 1'b0);
    chk("hold_tlr", 64'(tstate), 64'(TLR));
    step(1'b0, 1'b0);

    // Default IR reads IDCODE
    scan_dr(32, 64'd0, d);
    chk("idcode", 64'(d[31:0]), 64'(32'h1000_0B6D));

    // BYPASS: one-cycle delay
    scan_ir(4'hF);
    scan_dr(8, 64'hA5, d);
    chk("bypass", 64'(d[7:0]), 64'(8'h4A));

    // DBUS write, ack after a few cycles
    scan_ir(4'h2);
    scan_dr(DW, 64'({8'h3C, 32'hDEAD_BEEF, 2'b10}), d);
    chk("wr_req", 64'({req, wr, addr, wdata}), 64'({1'b1, 1'b1, 8'h3C, 32'hDEAD_BEEF}));
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    ack = 1'b1; step(1'b0, 1'b0); ack = 1'b0;
    chk("wr_req_drop", 64'(req), 64'd0);

    // DBUS read, then capture the returned data
    scan_dr(DW, 64'({8'h10, 32'h0, 2'b01}), d);
    chk("rd_req", 64'({req, wr, addr}), 64'({1'b1, 1'b0, 8'h10}));
    rdata = 32'h1234_5678; ack = 1'b1; step(1'b0, 1'b0); ack = 1'b0; rdata = '0;
    scan_dr(DW, 64'd0, d);
    chk("rd_capture", 64'(d[DW-1:0]), 64'({8'h10, 32'h1234_5678, 2'b00}));

    // Busy handling and sticky status
    scan_dr(DW, 64'({8'h55, 32'h1111_1111, 2'b10}), d);
    scan_dr(DW, 64'({8'h66, 32'h2222_2222, 2'b10}), d);
    chk("busy_keep_addr", 64'(addr), 64'(8'h55));
    scan_dr(DW, 64'({8'h77, 32'h0, 2'b11}), d);
    chk("status_busy", 64'(d[1:0]), 64'(2'b11));
    ack = 1'b1; step(1'b0, 1'b0); ack = 1'b0;
    scan_dr(DW, 64'd0, d);
    chk("status_sticky", 64'(d[1:0]), 64'(2'b11));
    scan_dr(DW, 64'({8'h77, 32'h0, 2'b01}), d);
    chk("status_clear", 64'(d[1:0]), 64'(2'b00));
    chk("rd2_req", 64'(req), 64'd1);

    // Reset while a request is outstanding
    @(negedge clk); #2; trst = 1'b1; #1;
    chk("trst_req_drop", 64'(req), 64'd0);
    chk("trst_state", 64'(tstate), 64'(TLR));
    model_reset();
    @(negedge clk); trst = 1'b0;
    step(1'b0, 1'b0);
    ack = 1'b1; repeat (3) step(1'b0, 1'b0); ack = 1'b0;

    // Random TMS walk; shifting ones never lands on the DBUS opcode
    walk = 1'b1;
    repeat (300) step(1'($urandom_range(1)), 1'b1);
    repeat (5) step(1'b1, 1'b1);
    walk = 1'b0;
    chk("walk_tlr", 64'(tstate), 64'(TLR));
    step(1'b0, 1'b0);

    // Random DBUS traffic with random acks
    scan_ir(4'h2);
    rand_ack = 1'b1;
    repeat (40) begin
      word = 64'({8'($urandom), 32'($urandom), 2'($urandom_range(3))});
      scan_dr(DW, word, d);
      repeat ($urandom_range(4)) step(1'b0, 1'b0);
    end
    rand_ack = 1'b0; ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
